// File: rtl/regfile_pkg.sv
// Shared defaults and the byte-lane merge used by the register file write and bypass paths.
package regfile_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int DEPTH_DEF   = 32;
  localparam int MERGE_MAX_W = 1024;
  localparam int MERGE_MAX_B = MERGE_MAX_W / 8;

  // Callers zero-extend into the fixed maximum width and truncate the result back.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_MAX_B-1:0] mask
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_MAX_B; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered count of busy registers.
module regfile_sb_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int CNT_W   = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set_valid,
  input  logic [ADDR_W-1:0] set_reg,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_reg,
  output logic [DEPTH-1:0]  busy,
  output logic [CNT_W-1:0]  busy_count
);

  logic             set_ok;
  logic             inc;
  logic             dec;
  logic [DEPTH-1:0] busy_next;
  logic [CNT_W-1:0] count_next;

  assign set_ok = set_valid && !((ZERO_REG != 0) && (set_reg == '0));

  // Clear first so a same-cycle issue to the retiring register keeps it busy.
  always_comb begin
    busy_next = busy;
    if (clr_valid) busy_next[clr_reg] = 1'b0;
    if (set_ok)    busy_next[set_reg] = 1'b1;
  end

  assign inc = set_ok && !busy[set_reg];
  assign dec = clr_valid && busy[clr_reg] && !(set_ok && (set_reg == clr_reg));

  always_comb begin
    count_next = busy_count;
    case ({inc, dec})
      2'b10:   count_next = busy_count + CNT_W'(1);
      2'b01:   count_next = busy_count - CNT_W'(1);
      default: count_next = busy_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with byte enables, optional hardwired zero register,
// same-cycle write bypass and a pending-write scoreboard for hazard detection.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [ADDR_W-1:0]  ReadRegister1,
  input  logic [ADDR_W-1:0]  ReadRegister2,
  output logic [WIDTH-1:0]   ReadData1,
  output logic [WIDTH-1:0]   ReadData2,
  output logic               Busy1,
  output logic               Busy2,
  input  logic [ADDR_W-1:0]  WriteRegister,
  input  logic [WIDTH-1:0]   WriteData,
  input  logic [WIDTH/8-1:0] WriteMask,
  input  logic               RegWrite,
  input  logic               IssueValid,
  input  logic [ADDR_W-1:0]  IssueRegister,
  output logic [ADDR_W:0]    BusyCount
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [WIDTH-1:0] merged;
  logic             write_ok;

  assign write_ok = RegWrite && !((ZERO_REG != 0) && (WriteRegister == '0));
  assign merged   = WIDTH'(byte_merge(MERGE_MAX_W'(regs[WriteRegister]),
                                      MERGE_MAX_W'(WriteData),
                                      MERGE_MAX_B'(WriteMask)));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (write_ok) begin
      regs[WriteRegister] <= merged;
    end
  end

  regfile_sb_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (Clk),
    .reset_n    (Reset_n),
    .set_valid  (IssueValid),
    .set_reg    (IssueRegister),
    .clr_valid  (RegWrite),
    .clr_reg    (WriteRegister),
    .busy       (busy),
    .busy_count (BusyCount)
  );

  // Zero-register override is applied last so it beats the bypass path.
  always_comb begin
    ReadData1 = regs[ReadRegister1];
    Busy1     = busy[ReadRegister1];
    if ((BYPASS != 0) && write_ok && (WriteRegister == ReadRegister1)) begin
      ReadData1 = merged;
      Busy1     = 1'b0;
    end
    if ((ZERO_REG != 0) && (ReadRegister1 == '0)) begin
      ReadData1 = '0;
      Busy1     = 1'b0;
    end
  end

  always_comb begin
    ReadData2 = regs[ReadRegister2];
    Busy2     = busy[ReadRegister2];
    if ((BYPASS != 0) && write_ok && (WriteRegister == ReadRegister2)) begin
      ReadData2 = merged;
      Busy2     = 1'b0;
    end
    if ((ZERO_REG != 0) && (ReadRegister2 == '0)) begin
      ReadData2 = '0;
      Busy2     = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default configuration and a BYPASS=0/ZERO_REG=0 variant share the
// same inputs and are checked every cycle against an array-based model, plus directed cases.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  rr1, rr2, wr, ir;
  logic [31:0] wd;
  logic [3:0]  wm;
  logic        rw, iv;

  logic [31:0] rd1 [2];
  logic [31:0] rd2 [2];
  logic        b1  [2];
  logic        b2  [2];
  logic [5:0]  cnt [2];

  logic [31:0] mreg  [2][32];
  logic [31:0] mbusy [2];
  bit          zero_flag   [2] = '{1'b1, 1'b0};
  bit          bypass_flag [2] = '{1'b1, 1'b0};
  bit          model_valid = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  regfile_sb dut0 (
    .Clk(clk), .Reset_n(reset_n),
    .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1[0]), .ReadData2(rd2[0]), .Busy1(b1[0]), .Busy2(b2[0]),
    .WriteRegister(wr), .WriteData(wd), .WriteMask(wm), .RegWrite(rw),
    .IssueValid(iv), .IssueRegister(ir), .BusyCount(cnt[0])
  );

  regfile_sb #(.ZERO_REG(0), .BYPASS(0)) dut1 (
    .Clk(clk), .Reset_n(reset_n),
    .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1[1]), .ReadData2(rd2[1]), .Busy1(b1[1]), .Busy2(b2[1]),
    .WriteRegister(wr), .WriteData(wd), .WriteMask(wm), .RegWrite(rw),
    .IssueValid(iv), .IssueRegister(ir), .BusyCount(cnt[1])
  );

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic bit is_zero(input int v, input logic [4:0] a);
    return zero_flag[v] && (a == 5'd0);
  endfunction

  function automatic bit forwarded(input int v, input logic [4:0] a);
    return bypass_flag[v] && rw && !is_zero(v, wr) && (wr == a);
  endfunction

  function automatic logic [31:0] exp_data(input int v, input logic [4:0] a);
    if (is_zero(v, a)) return 32'd0;
    if (forwarded(v, a)) return lane_merge(mreg[v][a], wd, wm);
    return mreg[v][a];
  endfunction

  function automatic logic exp_busy(input int v, input logic [4:0] a);
    if (is_zero(v, a) || forwarded(v, a)) return 1'b0;
    return mbusy[v][a];
  endfunction

  // Reference state: the register contents and busy set as the rules describe them.
  always @(posedge clk) begin
    for (int v = 0; v < 2; v++) begin
      if (!reset_n) begin
        for (int r = 0; r < 32; r++) mreg[v][r] <= 32'd0;
        mbusy[v] <= 32'd0;
      end else begin
        if (rw && !is_zero(v, wr)) mreg[v][wr] <= lane_merge(mreg[v][wr], wd, wm);
        if (rw) mbusy[v][wr] <= 1'b0;
        if (iv && !is_zero(v, ir)) mbusy[v][ir] <= 1'b1;
      end
    end
    if (!reset_n) model_valid <= 1'b1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      for (int v = 0; v < 2; v++) begin
        checkOutput($sformatf("dut%0d ReadData1", v), 64'(rd1[v]), 64'(exp_data(v, rr1)));
        checkOutput($sformatf("dut%0d ReadData2", v), 64'(rd2[v]), 64'(exp_data(v, rr2)));
        checkOutput($sformatf("dut%0d Busy1", v),     64'(b1[v]),  64'(exp_busy(v, rr1)));
        checkOutput($sformatf("dut%0d Busy2", v),     64'(b2[v]),  64'(exp_busy(v, rr2)));
        checkOutput($sformatf("dut%0d BusyCount", v), 64'(cnt[v]), 64'($countones(mbusy[v])));
      end
    end
  end

  task automatic applyStimulus(input logic n_rst, input logic w_en, input logic [4:0] w_reg,
                               input logic [31:0] w_data, input logic [3:0] w_mask,
                               input logic i_en, input logic [4:0] i_reg,
                               input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    reset_n = n_rst; rw = w_en; wr = w_reg; wd = w_data; wm = w_mask;
    iv = i_en; ir = i_reg; rr1 = r1; rr2 = r2;
  endtask

  initial begin
    reset_n = 1'b0; rw = 1'b0; wr = '0; wd = '0; wm = '0; iv = 1'b0; ir = '0; rr1 = '0; rr2 = '0;
    repeat (2) @(posedge clk);

    for (int r = 0; r < 32; r++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 5'(r), 5'(31 - r));
      @(negedge clk);
      checkOutput("reset rd1", 64'(rd1[0]), 64'd0);
      checkOutput("reset rd2", 64'(rd2[1]), 64'd0);
      checkOutput("reset busy", 64'({b1[0], b2[0], b1[1], b2[1]}), 64'd0);
      checkOutput("reset count", 64'(cnt[0]), 64'd0);
    end

    applyStimulus(1, 1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 5, 5);
    applyStimulus(1, 1, 5, 32'h00001234, 4'h3, 0, 0, 5, 5);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 5, 5);
    @(negedge clk);
    checkOutput("mask dut0", 64'(rd1[0]), 64'hDEAD1234);
    checkOutput("mask dut1", 64'(rd2[1]), 64'hDEAD1234);
    checkOutput("mask model", 64'(mreg[0][5]), 64'hDEAD1234);

    applyStimulus(1, 1, 7, 32'h2A, 4'hF, 0, 0, 7, 7);
    @(negedge clk);
    checkOutput("bypass data", 64'(rd1[0]), 64'h2A);
    checkOutput("bypass busy", 64'(b1[0]), 64'd0);
    checkOutput("nobypass data", 64'(rd1[1]), 64'd0);

    applyStimulus(1, 1, 0, 32'h2A, 4'hF, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("zero rd", 64'({rd1[0], rd2[0]}), 64'd0);
    checkOutput("zero busy", 64'({b1[0], b2[0]}), 64'd0);
    checkOutput("zero count", 64'(cnt[0]), 64'd0);
    checkOutput("r0 plain data", 64'(rd1[1]), 64'h2A);
    checkOutput("r0 plain count", 64'(cnt[1]), 64'd1);

    applyStimulus(1, 1, 0, 0, 4'h0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 3, 4);
    applyStimulus(1, 0, 0, 0, 0, 1, 4, 3, 4);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 3, 4);
    @(negedge clk);
    checkOutput("issue count", 64'(cnt[0]), 64'd2);
    checkOutput("issue busy", 64'({b1[0], b2[0]}), 64'b11);
    checkOutput("issue count plain", 64'(cnt[1]), 64'd2);

    applyStimulus(1, 1, 3, 32'h77, 4'hF, 1, 3, 3, 4);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 3, 4);
    @(negedge clk);
    checkOutput("set wins data", 64'(rd1[0]), 64'h77);
    checkOutput("set wins busy", 64'(b1[0]), 64'd1);
    checkOutput("set wins count", 64'(cnt[0]), 64'd2);

    applyStimulus(1, 1, 4, 32'h0, 4'h0, 0, 0, 3, 4);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 3, 4);
    @(negedge clk);
    checkOutput("retire count", 64'(cnt[0]), 64'd1);
    checkOutput("retire busy", 64'(b2[0]), 64'd0);

    applyStimulus(0, 1, 9, 32'h55, 4'hF, 1, 9, 9, 9);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 9, 3);
    @(negedge clk);
    checkOutput("reset wins data", 64'(rd1[0]), 64'd0);
    checkOutput("reset wins busy", 64'({b1[0], b2[0]}), 64'd0);
    checkOutput("reset wins count", 64'({cnt[0], cnt[1]}), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] a_w, a_i, a_1, a_2;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      a_w = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a_i = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a_1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a_2 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      applyStimulus(($urandom_range(0, 99) != 0), 1'($urandom), a_w, $urandom, 4'($urandom),
                    ($urandom_range(0, 2) != 0), a_i, a_1, a_2);
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
